msdap_da_accum_mc: RTL and testbench



---
 rtl/msdap_da_accum_mc_if.sv | 34 +++
 rtl/msdap_da_accum_mc.sv | 154 +++++++++++++++
 tb/tb_msdap_da_accum_mc.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msdap_da_accum_mc_if.sv
// Handshake and data bundle between the fetch unit, the DA accumulator and the output serializer.
// The master side drives requests and terms; the slave side is the accumulator itself.
interface msdap_da_accum_mc_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 10,
    parameter int CH_W   = 1
);
    logic              start;
    logic [CH_W-1:0]   start_ch;
    logic              busy;
    logic              grp_req;
    logic [LEN_W-1:0]  grp_len;
    logic [4:0]        rj_idx;
    logic              term_valid;
    logic              term_ready;
    logic [DATA_W-1:0] term_data;
    logic              term_sign;
    logic              result_valid;
    logic              result_ready;
    logic [ACC_W-1:0]  result_data;
    logic [CH_W-1:0]   result_ch;
    logic              result_ovf;

    modport master (
        output start, start_ch, grp_len, term_valid, term_data, term_sign, result_ready,
        input  busy, grp_req, rj_idx, term_ready, result_valid, result_data, result_ch, result_ovf
    );

    modport slave (
        input  start, start_ch, grp_len, term_valid, term_data, term_sign, result_ready,
        output busy, grp_req, rj_idx, term_ready, result_valid, result_data, result_ch, result_ovf
    );
endinterface

// File: rtl/msdap_da_accum_mc.sv
// Multi-channel distributed-arithmetic y(n) engine: per group, sum sign-weighted terms into u,
// then fold u into the running total and halve it; the channel tag travels with the sample.
module msdap_da_accum_mc #(
    parameter int DATA_W  = 16,
    parameter int GUARD_W = 8,
    parameter int ACC_W   = 40,
    parameter int RJ_NUM  = 16,
    parameter int LEN_W   = 10,
    parameter int CH_W    = 1,
    parameter int SAT_EN  = 0
) (
    input logic clk,
    input logic reset,
    msdap_da_accum_mc_if.slave bus
);
    localparam int SH_W   = ACC_W - DATA_W - GUARD_W;
    localparam int TERM_W = DATA_W + GUARD_W;
    localparam logic [4:0] LAST = 5'(RJ_NUM - 1);

    typedef enum logic [2:0] {IDLE, GRP, ACCUM, SHIFT, OUT} state_t;

    state_t                   state, state_nx;
    logic signed [ACC_W-1:0]  u_p0;
    logic signed [ACC_W-1:0]  acc_p1;
    logic [LEN_W-1:0]         len_p0;
    logic [LEN_W-1:0]         cnt_p0;
    logic [4:0]               rj_idx_r;
    logic [CH_W-1:0]          ch_r;
    logic                     ovf_r;

    logic signed [ACC_W-1:0]  term_p0;
    logic signed [ACC_W-1:0]  u_sum;
    logic signed [ACC_W-1:0]  acc_sum;
    logic                     u_ovf;
    logic                     acc_ovf;
    logic                     grp_req_c, term_ready_c, busy_c, result_valid_c;

    function automatic logic signed [ACC_W-1:0] form_term(input logic [DATA_W-1:0] d,
                                                          input logic neg);
        logic signed [DATA_W-1:0] ds;
        logic signed [TERM_W-1:0] ext;
        ds  = d;
        ext = TERM_W'(ds);
        if (neg)
            ext = -ext;
        return {ext, {SH_W{1'b0}}};
    endfunction

    // Returns {overflow, sum}; with saturation enabled the sum clamps to the signed rail.
    function automatic logic [ACC_W:0] add_sat(input logic signed [ACC_W-1:0] a,
                                               input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W-1:0] s;
        logic                    ovf;
        s   = a + b;
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
        if (ovf && SAT_EN != 0)
            s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return {ovf, s};
    endfunction

    assign term_p0            = form_term(bus.term_data, bus.term_sign);
    assign {u_ovf, u_sum}     = add_sat(u_p0, term_p0);
    assign {acc_ovf, acc_sum} = add_sat(acc_p1, u_p0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        grp_req_c      = 1'b0;
        term_ready_c   = 1'b0;
        busy_c         = 1'b1;
        result_valid_c = 1'b0;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.start)
                    state_nx = GRP;
            end
            GRP: begin
                grp_req_c = 1'b1;
                state_nx  = (bus.grp_len == '0) ? SHIFT : ACCUM;
            end
            ACCUM: begin
                term_ready_c = 1'b1;
                if (bus.term_valid && cnt_p0 == len_p0 - LEN_W'(1))
                    state_nx = SHIFT;
            end
            SHIFT: state_nx = (rj_idx_r == LAST) ? OUT : GRP;
            OUT: begin
                result_valid_c = 1'b1;
                if (bus.result_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            u_p0     <= '0;
            acc_p1   <= '0;
            len_p0   <= '0;
            cnt_p0   <= '0;
            rj_idx_r <= '0;
            ch_r     <= '0;
            ovf_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    ch_r     <= bus.start_ch;
                    u_p0     <= '0;
                    acc_p1   <= '0;
                    rj_idx_r <= '0;
                    ovf_r    <= 1'b0;
                end
                GRP: begin
                    len_p0 <= bus.grp_len;
                    cnt_p0 <= '0;
                end
                // term stage: u_p0 collects the group's sign-weighted terms
                ACCUM: if (bus.term_valid) begin
                    u_p0   <= u_sum;
                    cnt_p0 <= cnt_p0 + LEN_W'(1);
                    if (u_ovf)
                        ovf_r <= 1'b1;
                end
                // group stage: fold u into the total and halve it
                SHIFT: begin
                    acc_p1 <= acc_sum >>> 1;
                    u_p0   <= '0;
                    if (rj_idx_r != LAST)
                        rj_idx_r <= rj_idx_r + 5'd1;
                    if (acc_ovf)
                        ovf_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = busy_c;
    assign bus.grp_req      = grp_req_c;
    assign bus.rj_idx       = rj_idx_r;
    assign bus.term_ready   = term_ready_c;
    assign bus.result_valid = result_valid_c;
    assign bus.result_data  = acc_p1;
    assign bus.result_ch    = ch_r;
    assign bus.result_ovf   = ovf_r;
endmodule

// File: tb/tb_msdap_da_accum_mc.sv
// Bench for msdap_da_accum_mc: directed and random samples checked against an integer model
// of the group-sum / halve recurrence, plus a saturating narrow instance.
module tb_msdap_da_accum_mc;
    localparam int RJ = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    msdap_da_accum_mc_if #(.DATA_W(16), .ACC_W(40), .LEN_W(10), .CH_W(1)) bus0 ();
    msdap_da_accum_mc_if #(.DATA_W(16), .ACC_W(30), .LEN_W(10), .CH_W(1)) bus1 ();

    msdap_da_accum_mc #(.DATA_W(16), .GUARD_W(8), .ACC_W(40), .RJ_NUM(RJ), .LEN_W(10),
                        .CH_W(1), .SAT_EN(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    msdap_da_accum_mc #(.DATA_W(16), .GUARD_W(0), .ACC_W(30), .RJ_NUM(RJ), .LEN_W(10),
                        .CH_W(1), .SAT_EN(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int lens0[32];
    int lens1[32];
    logic [15:0] tdata[$];
    bit          tsign[$];
    int n_cmp = 0;
    int n_err = 0;

    assign bus0.grp_len = 10'(lens0[bus0.rj_idx]);
    assign bus1.grp_len = 10'(lens1[bus1.rj_idx]);

    function automatic longint wrapw(input longint x, input int w);
        return (x <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic longint fit(input longint s, input int w, input bit sat);
        longint mx;
        mx = (longint'(1) <<< (w - 1)) - 1;
        if (s > mx)      return sat ? mx : wrapw(s, w);
        if (s < -mx - 1) return sat ? -mx - 1 : wrapw(s, w);
        return s;
    endfunction

    // y = sum over groups of u_j, halving after each group; terms taken in order from the queues.
    function automatic void ref_model(input int lens[32], input int acc_w, input int sh_w,
                                      input int tw, input bit sat,
                                      output longint res, output bit ovf);
        longint acc, u, d, s;
        int k;
        acc = 0; ovf = 0; k = 0;
        for (int j = 0; j < RJ; j++) begin
            u = 0;
            for (int n = 0; n < lens[j]; n++) begin
                d = longint'($signed(tdata[k]));
                if (tsign[k]) d = -d;
                d = wrapw(d, tw) * (longint'(1) <<< sh_w);
                s = u + d;
                if (fit(s, acc_w, 1'b0) != s) ovf = 1;
                u = fit(s, acc_w, sat);
                k++;
            end
            s = acc + u;
            if (fit(s, acc_w, 1'b0) != s) ovf = 1;
            acc = fit(s, acc_w, sat) >>> 1;
        end
        res = acc;
    endfunction

    function automatic logic [63:0] msk(input longint v, input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return 64'(v) & m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one sample on bus0 from the current negedge; term_valid drops for gap cycles after each term.
    task automatic run0(input int gap, input logic ch, input int abort_grp,
                        output int lat, output int trc, output int stalls, output int greq,
                        output bit done);
        int idx, gcnt;
        bit tv;
        idx = 0; gcnt = 0; lat = -1; trc = 0; stalls = 0; greq = 0; done = 0;
        bus0.start = 1'b1;
        bus0.start_ch = ch;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i == 0) bus0.start = 1'b0;
            if (bus0.result_valid) begin
                lat = i; done = 1; break;
            end
            if (abort_grp >= 0 && bus0.term_ready && int'(bus0.rj_idx) == abort_grp) begin
                reset = 1'b0; done = 1; break;
            end
            if (bus0.grp_req) greq++;
            if (bus0.term_ready) trc++;
            tv = (gcnt == 0);
            if (bus0.term_ready && !tv) begin stalls++; gcnt--; end
            bus0.term_valid = tv;
            bus0.term_data  = (idx < tdata.size()) ? tdata[idx] : 16'h0;
            bus0.term_sign  = (idx < tsign.size()) ? tsign[idx] : 1'b0;
            if (bus0.term_ready && tv) begin idx++; gcnt = gap; end
        end
        bus0.term_valid = 1'b0;
    endtask

    // Holds result_ready low for hold cycles (pulsing start), then completes the handshake with start high.
    task automatic ack0(input int hold, input logic [63:0] exp_d, input logic exp_ch);
        for (int i = 0; i < hold; i++) begin
            bus0.start = (i == 2);
            bus0.start_ch = 1'b1;
            @(negedge clk);
            chk("hold_valid", 64'(bus0.result_valid), 64'd1);
            chk("hold_data", 64'(bus0.result_data), exp_d);
            chk("hold_ch", 64'(bus0.result_ch), 64'(exp_ch));
        end
        bus0.start = (hold > 0);
        bus0.result_ready = 1'b1;
        @(negedge clk);
        bus0.result_ready = 1'b0;
        bus0.start = 1'b0;
        chk("ack_valid_drop", 64'(bus0.result_valid), 64'd0);
        chk("ack_idle", 64'(bus0.busy), 64'd0);
    endtask

    task automatic set_uniform(input int len, input logic [15:0] d, input bit s);
        tdata.delete(); tsign.delete();
        for (int j = 0; j < 32; j++) lens0[j] = (j < RJ) ? len : 0;
        for (int k = 0; k < RJ * len; k++) begin tdata.push_back(d); tsign.push_back(s); end
    endtask

    task automatic set_single(input int grp, input logic [15:0] d);
        tdata.delete(); tsign.delete();
        for (int j = 0; j < 32; j++) lens0[j] = (j == grp) ? 1 : 0;
        tdata.push_back(d); tsign.push_back(1'b0);
    endtask

    initial begin
        int lat, trc, stalls, greq, suml;
        bit done, movf;
        longint mres;
        logic [63:0] dval;

        bus0.start = 0; bus0.start_ch = 0; bus0.term_valid = 0; bus0.term_data = 0;
        bus0.term_sign = 0; bus0.result_ready = 0;
        bus1.start = 0; bus1.start_ch = 0; bus1.term_valid = 0; bus1.term_data = 0;
        bus1.term_sign = 0; bus1.result_ready = 0;
        for (int j = 0; j < 32; j++) begin lens0[j] = 0; lens1[j] = 0; end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus0.busy), 64'd0);
        chk("rst_grp_req", 64'(bus0.grp_req), 64'd0);
        chk("rst_term_ready", 64'(bus0.term_ready), 64'd0);
        chk("rst_result_valid", 64'(bus0.result_valid), 64'd0);
        chk("rst_result_data", 64'(bus0.result_data), 64'd0);
        chk("rst_rj_idx", 64'(bus0.rj_idx), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // all groups length 1, positive term
        set_uniform(1, 16'h4000, 1'b0);
        run0(0, 1'b0, -1, lat, trc, stalls, greq, done);
        chk("A_done", 64'(done), 64'd1);
        chk("A_data", 64'(bus0.result_data), 64'h003FFFC000);
        chk("A_ovf", 64'(bus0.result_ovf), 64'd0);
        chk("A_latency", 64'(lat), 64'd48);
        chk("A_grp_req_pulses", 64'(greq), 64'd16);
        ack0(0, 64'h003FFFC000, 1'b0);

        set_uniform(1, 16'h4000, 1'b1);
        run0(0, 1'b0, -1, lat, trc, stalls, greq, done);
        chk("B_data", 64'(bus0.result_data), 64'hFFC0004000);
        ack0(0, 64'hFFC0004000, 1'b0);

        set_single(0, 16'h0001);
        run0(0, 1'b0, -1, lat, trc, stalls, greq, done);
        chk("G0_data", 64'(bus0.result_data), 64'h0000000001);
        chk("G0_latency", 64'(lat), 64'd33);
        ack0(0, 64'h1, 1'b0);

        set_single(15, 16'h0001);
        run0(0, 1'b0, -1, lat, trc, stalls, greq, done);
        chk("G15_data", 64'(bus0.result_data), 64'h0000008000);
        ack0(0, 64'h8000, 1'b0);

        set_uniform(0, 16'h0, 1'b0);
        run0(0, 1'b0, -1, lat, trc, stalls, greq, done);
        chk("Z_data", 64'(bus0.result_data), 64'd0);
        chk("Z_latency", 64'(lat), 64'd32);
        chk("Z_term_ready_cycles", 64'(trc), 64'd0);
        ack0(0, 64'd0, 1'b0);

        // two groups of three mixed terms with 2-cycle valid gaps
        tdata.delete(); tsign.delete();
        for (int j = 0; j < 32; j++) lens0[j] = (j < 2) ? 3 : 0;
        for (int g = 0; g < 2; g++) begin
            tdata.push_back(16'h7FFF); tsign.push_back(1'b0);
            tdata.push_back(16'h8000); tsign.push_back(1'b1);
            tdata.push_back(16'h0001); tsign.push_back(1'b0);
        end
        ref_model(lens0, 40, 16, 24, 1'b0, mres, movf);
        run0(2, 1'b0, -1, lat, trc, stalls, greq, done);
        chk("M_data", 64'(bus0.result_data), msk(mres, 40));
        chk("M_data_const", 64'(bus0.result_data), 64'h30000);
        chk("M_stalls", 64'(stalls), 64'd10);
        chk("M_latency", 64'(lat), 64'(38 + stalls));
        chk("M_term_ready_cycles", 64'(trc), 64'(6 + stalls));
        ack0(0, msk(mres, 40), 1'b0);

        // result held under back-pressure, start ignored while busy
        set_uniform(1, 16'h4000, 1'b0);
        run0(0, 1'b0, -1, lat, trc, stalls, greq, done);
        ack0(5, 64'h003FFFC000, 1'b0);
        @(negedge clk);
        chk("H_still_idle", 64'(bus0.busy), 64'd0);
        run0(0, 1'b1, -1, lat, trc, stalls, greq, done);
        chk("H_ch1_tag", 64'(bus0.result_ch), 64'd1);
        chk("H_ch1_data", 64'(bus0.result_data), 64'h003FFFC000);
        ack0(0, 64'h003FFFC000, 1'b1);

        // wrap overflow on the default instance
        tdata.delete(); tsign.delete();
        for (int j = 0; j < 32; j++) lens0[j] = (j == 0) ? 300 : 0;
        for (int k = 0; k < 300; k++) begin tdata.push_back(16'h7FFF); tsign.push_back(1'b0); end
        ref_model(lens0, 40, 16, 24, 1'b0, mres, movf);
        run0(0, 1'b0, -1, lat, trc, stalls, greq, done);
        chk("W_ovf", 64'(bus0.result_ovf), 64'd1);
        chk("W_data", 64'(bus0.result_data), msk(mres, 40));
        ack0(0, msk(mres, 40), 1'b0);

        // abort in the middle of group 7
        set_uniform(1, 16'h4000, 1'b0);
        run0(0, 1'b0, 7, lat, trc, stalls, greq, done);
        chk("R_reached_g7", 64'(done), 64'd1);
        #1;
        chk("R_busy", 64'(bus0.busy), 64'd0);
        chk("R_term_ready", 64'(bus0.term_ready), 64'd0);
        chk("R_rj_idx", 64'(bus0.rj_idx), 64'd0);
        chk("R_result_valid", 64'(bus0.result_valid), 64'd0);
        chk("R_result_data", 64'(bus0.result_data), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        set_single(0, 16'h0001);
        run0(0, 1'b0, -1, lat, trc, stalls, greq, done);
        chk("R_clean_data", 64'(bus0.result_data), 64'h1);
        chk("R_clean_ovf", 64'(bus0.result_ovf), 64'd0);
        ack0(0, 64'h1, 1'b0);

        // random samples against the model
        for (int r = 0; r < 4; r++) begin
            int gap;
            logic ch;
            tdata.delete(); tsign.delete();
            suml = 0;
            for (int j = 0; j < 32; j++) begin
                lens0[j] = (j < RJ) ? int'($urandom_range(0, 3)) : 0;
                suml += lens0[j];
            end
            for (int k = 0; k < suml; k++) begin
                tdata.push_back(16'($urandom_range(0, 16'hFFFF)));
                tsign.push_back(1'($urandom_range(0, 1)));
            end
            gap = $urandom_range(0, 2);
            ch = 1'($urandom_range(0, 1));
            ref_model(lens0, 40, 16, 24, 1'b0, mres, movf);
            run0(gap, ch, -1, lat, trc, stalls, greq, done);
            chk("RND_data", 64'(bus0.result_data), msk(mres, 40));
            chk("RND_ovf", 64'(bus0.result_ovf), 64'(movf));
            chk("RND_ch", 64'(bus0.result_ch), 64'(ch));
            chk("RND_latency", 64'(lat), 64'(suml + 2 * RJ + stalls));
            ack0(0, msk(mres, 40), ch);
        end

        // saturating narrow instance: 300 max-positive terms in group 0
        tdata.delete(); tsign.delete();
        for (int j = 0; j < 32; j++) lens1[j] = (j == 0) ? 300 : 0;
        for (int k = 0; k < 300; k++) begin tdata.push_back(16'h7FFF); tsign.push_back(1'b0); end
        ref_model(lens1, 30, 14, 16, 1'b1, mres, movf);
        bus1.start = 1'b1;
        bus1.term_valid = 1'b1;
        bus1.term_data = 16'h7FFF;
        bus1.term_sign = 1'b0;
        done = 0; lat = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (i == 0) bus1.start = 1'b0;
            if (bus1.result_valid) begin lat = i; done = 1; break; end
        end
        bus1.term_valid = 1'b0;
        dval = 64'(bus1.result_data);
        chk("S_done", 64'(done), 64'd1);
        chk("S_ovf", 64'(bus1.result_ovf), 64'd1);
        chk("S_data_model", dval, msk(mres, 30));
        chk("S_data_const", dval, 64'h1FFF);
        chk("S_latency", 64'(lat), 64'd332);
        bus1.result_ready = 1'b1;
        @(negedge clk);
        bus1.result_ready = 1'b0;
        chk("S_ack_idle", 64'(bus1.busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
